// File: rtl/gelu_vec_pipe_if.sv
// gelu_vec_pipe_if -- stream bundle for gelu_vec_pipe.
//
// Carries both the input beat stream (s_*) and the output beat stream (m_*).
//   master : the side producing input beats and consuming output beats
//   slave  : the GELU pipeline itself
// Signals:
//   s_valid/s_ready  input handshake, s_scale fractional bits, s_x packed lanes
//   s_bypass         present only when GELU_BYPASS_EN is defined
//   m_valid/m_ready  output handshake, m_scale clamped scale, m_y packed lanes
interface gelu_vec_pipe_if #(
    parameter int DW      = 8,
    parameter int LANES   = 4,
    parameter int SCALE_W = 3
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic [SCALE_W-1:0]    s_scale;
    logic [LANES*DW-1:0]   s_x;
`ifdef GELU_BYPASS_EN
    logic                  s_bypass;
`endif
    logic                  m_valid;
    logic                  m_ready;
    logic [SCALE_W-1:0]    m_scale;
    logic [LANES*DW-1:0]   m_y;

    modport master (
`ifdef GELU_BYPASS_EN
        output s_bypass,
`endif
        output s_valid, s_scale, s_x, m_ready,
        input  s_ready, m_valid, m_scale, m_y
    );

    modport slave (
`ifdef GELU_BYPASS_EN
        input  s_bypass,
`endif
        input  s_valid, s_scale, s_x, m_ready,
        output s_ready, m_valid, m_scale, m_y
    );
endinterface

// File: rtl/gelu_vec_pipe.sv
// gelu_vec_pipe -- LANES-wide streaming GELU with valid/ready backpressure.
//
// Each beat carries LANES signed DW-bit values sharing one fractional scale.
// Output lane = GELU(input lane) at the same scale, rounded to nearest (ties away
// from zero) and saturated. Latency is LAT cycles; one global enable stalls the
// whole pipeline so bubbles are preserved and order is kept.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears every stage valid)
//   io   gelu_vec_pipe_if.slave: s_valid/s_ready/s_scale/s_x[/s_bypass] in,
//        m_valid/m_ready/m_scale/m_y out
// Optional feature: define GELU_BYPASS_EN to add s_bypass; bypass beats return
// s_x unchanged with the same latency and ordering.
module gelu_vec_pipe #(
    parameter int DW        = 8,
    parameter int LANES     = 4,
    parameter int SCALE_W   = 3,
    parameter int MAX_SCALE = 6,
    parameter int LAT       = 8
) (
    input  logic           clk,
    input  logic           rst,
    gelu_vec_pipe_if.slave io
);
    // Inputs are renormalised to NF fractional bits; the table has four segments
    // per unit, so FB bits remain as the interpolation fraction.
    localparam int NF  = (MAX_SCALE > 3) ? MAX_SCALE : 3;
    localparam int FB  = NF - 2;
    localparam int XW  = DW + NF + 1;
    localparam int YW  = DW + NF + 12;
    localparam int YW1 = YW + 1;
    localparam logic signed [XW-1:0] PASS_TH = XW'(7 <<< (NF - 1));
    localparam logic signed [XW-1:0] ZERO_TH = -XW'(4 <<< NF);
    localparam logic signed [YW:0]   Y_MAX   = YW1'((1 <<< (DW - 1)) - 1);
    localparam logic signed [YW:0]   Y_MIN   = -YW1'(1 <<< (DW - 1));

    // GELU(-k/4) in Q12 for k = 0..16; positive inputs use GELU(t) = t + GELU(-t).
    function automatic logic signed [11:0] gelu_tab(input logic [4:0] k);
        case (k)
            5'd1:    gelu_tab = -12'sd411;
            5'd2:    gelu_tab = -12'sd632;
            5'd3:    gelu_tab = -12'sd696;
            5'd4:    gelu_tab = -12'sd650;
            5'd5:    gelu_tab = -12'sd542;
            5'd6:    gelu_tab = -12'sd411;
            5'd7:    gelu_tab = -12'sd288;
            5'd8:    gelu_tab = -12'sd186;
            5'd9:    gelu_tab = -12'sd111;
            5'd10:   gelu_tab = -12'sd62;
            5'd11:   gelu_tab = -12'sd32;
            5'd12:   gelu_tab = -12'sd15;
            5'd13:   gelu_tab = -12'sd6;
            5'd14:   gelu_tab = -12'sd3;
            5'd15:   gelu_tab = -12'sd1;
            default: gelu_tab = 12'sd0;
        endcase
    endfunction

    // Unrounded result with NF+10 fractional bits. Bypass and large positive
    // inputs are re-expressed exactly so the rounding stage returns x unchanged.
    function automatic logic signed [YW-1:0] gelu_fix(input logic signed [DW-1:0] x,
                                                      input logic [SCALE_W-1:0] s,
                                                      input logic byp);
        logic signed [XW-1:0] xn;
        logic signed [XW-1:0] mag;
        logic [4:0]           k;
        logic [FB-1:0]        fr;
        logic signed [11:0]   t0;
        logic signed [11:0]   t1;
        logic signed [YW-1:0] g;
        xn  = XW'(x) <<< (NF - int'(s));
        mag = (xn < 0) ? -xn : xn;
        k   = 5'(mag >>> FB);
        fr  = FB'(mag);
        t0  = gelu_tab(k);
        t1  = gelu_tab(k + 5'd1);
        g   = (YW'(t0) <<< FB) + YW'(t1 - t0) * YW'($signed({1'b0, fr}));
        if (byp || xn >= PASS_TH)
            gelu_fix = YW'(x) <<< (NF + 10 - int'(s));
        else if (xn <= ZERO_TH)
            gelu_fix = '0;
        else
            gelu_fix = g + ((xn > 0) ? (YW'(xn) <<< 10) : '0);
    endfunction

    // Back to the beat's own scale: round half away from zero, then saturate.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [YW-1:0] acc,
                                                       input logic [SCALE_W-1:0] s);
        logic signed [YW:0] a;
        logic signed [YW:0] half;
        logic signed [YW:0] q;
        int                 sh;
        sh   = NF + 10 - int'(s);
        half = YW1'(1) <<< (sh - 1);
        a    = (acc < 0) ? -YW1'(acc) : YW1'(acc);
        q    = (a + half) >>> sh;
        if (acc < 0)
            q = -q;
        if (q > Y_MAX)
            q = Y_MAX;
        else if (q < Y_MIN)
            q = Y_MIN;
        round_sat = DW'(q);
    endfunction

    logic                          en;
    logic [SCALE_W-1:0]            s_scale_c;
    logic                          vld_p0, vld_p1, vld_p2;
    logic [SCALE_W-1:0]            scl_p0, scl_p1, scl_p2;
    logic [LANES-1:0][DW-1:0]      x_p0;
    logic                          byp_p0;
    logic [LANES-1:0][YW-1:0]      acc_p1;
    logic [LANES-1:0][DW-1:0]      y_p2;
    logic                          out_vld;
    logic [SCALE_W-1:0]            out_scl;
    logic [LANES-1:0][DW-1:0]      out_y;

    assign en         = io.m_ready | ~out_vld;
    assign io.s_ready = en;
    assign s_scale_c  = (io.s_scale > SCALE_W'(MAX_SCALE)) ? SCALE_W'(MAX_SCALE) : io.s_scale;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= io.s_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // p0: capture beat with clamped scale
            scl_p0 <= s_scale_c;
            x_p0   <= io.s_x;
            // p1: table interpolation per lane
            scl_p1 <= scl_p0;
            for (int i = 0; i < LANES; i++)
                acc_p1[i] <= gelu_fix($signed(x_p0[i]), scl_p0, byp_p0);
            // p2: round and saturate
            scl_p2 <= scl_p1;
            for (int i = 0; i < LANES; i++)
                y_p2[i] <= round_sat($signed(acc_p1[i]), scl_p1);
        end
    end

`ifdef GELU_BYPASS_EN
    always_ff @(posedge clk) begin
        if (en)
            byp_p0 <= io.s_bypass;
    end
`else
    assign byp_p0 = 1'b0;
`endif

    generate
        if (LAT > 3) begin : g_dly
            logic [LAT-4:0]                          vld_d;
            logic [LAT-4:0][SCALE_W-1:0]             scl_d;
            logic [LAT-4:0][LANES-1:0][DW-1:0]       y_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_d <= '0;
                end else if (en) begin
                    vld_d[0] <= vld_p2;
                    for (int i = 1; i < LAT - 3; i++)
                        vld_d[i] <= vld_d[i-1];
                end
            end

            // p3..: pure delay to reach the configured latency
            always_ff @(posedge clk) begin
                if (en) begin
                    scl_d[0] <= scl_p2;
                    y_d[0]   <= y_p2;
                    for (int i = 1; i < LAT - 3; i++) begin
                        scl_d[i] <= scl_d[i-1];
                        y_d[i]   <= y_d[i-1];
                    end
                end
            end

            assign out_vld = vld_d[LAT-4];
            assign out_scl = scl_d[LAT-4];
            assign out_y   = y_d[LAT-4];
        end else begin : g_nodly
            assign out_vld = vld_p2;
            assign out_scl = scl_p2;
            assign out_y   = y_p2;
        end
    endgenerate

    // Data registers are not reset; gating on valid keeps outputs at zero when idle.
    assign io.m_valid = out_vld;
    assign io.m_scale = out_vld ? out_scl : '0;
    assign io.m_y     = out_vld ? out_y : '0;
endmodule

// File: tb/tb_gelu_vec_pipe.sv
// tb_gelu_vec_pipe -- self-checking bench for gelu_vec_pipe (DW=8, LANES=4, LAT=8).
// Expected lanes come from a real-valued GELU model; accepted beats are queued and
// matched in order against output handshakes.
module tb_gelu_vec_pipe;
    localparam int DW        = 8;
    localparam int LANES     = 4;
    localparam int SCALE_W   = 3;
    localparam int MAX_SCALE = 6;
    localparam int LAT       = 8;

    logic clk = 1'b0;
    logic rst;

    gelu_vec_pipe_if #(.DW(DW), .LANES(LANES), .SCALE_W(SCALE_W)) io ();

    gelu_vec_pipe #(
        .DW(DW), .LANES(LANES), .SCALE_W(SCALE_W), .MAX_SCALE(MAX_SCALE), .LAT(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    int err = 0;
    int chk = 0;
    int n_in = 0;
    int n_out = 0;
    logic got_out;

    logic [LANES*DW-1:0] q_y[$];
    int                  q_scl[$];
    int                  q_tol[$];

    logic [LANES*DW-1:0] cur_y;
    int                  cur_scl;
    int                  cur_tol;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        chk++;
        if ((obs - exp) > tol || (exp - obs) > tol) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    function automatic int gelu_ref(input int x, input int s);
        real xr, yr, c;
        int  y;
        xr = real'(x) / real'(1 << s);
        if (xr >= 3.5) return x;
        if (xr <= -4.0) return 0;
        c  = $sqrt(2.0 / 3.14159265358979);
        yr = 0.5 * xr * (1.0 + $tanh(c * (xr + 0.044715 * xr * xr * xr))) * real'(1 << s);
        if (yr >= 0.0) y = $rtoi($floor(yr + 0.5));
        else           y = -$rtoi($floor(-yr + 0.5));
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    function automatic logic [LANES*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [LANES*DW-1:0] v;
        v[0*DW +: DW] = DW'(a);
        v[1*DW +: DW] = DW'(b);
        v[2*DW +: DW] = DW'(c);
        v[3*DW +: DW] = DW'(d);
        return v;
    endfunction

    task automatic drive(input int scl, input logic [LANES*DW-1:0] x, input logic byp,
                         input logic [LANES*DW-1:0] ey, input int tol);
        io.s_valid = 1'b1;
        io.s_scale = SCALE_W'(scl);
        io.s_x     = x;
`ifdef GELU_BYPASS_EN
        io.s_bypass = byp;
`endif
        cur_y   = ey;
        cur_scl = (scl > MAX_SCALE) ? MAX_SCALE : scl;
        cur_tol = (byp === 1'b1) ? 0 : tol;
    endtask

    task automatic rand_beat();
        int                  scl, sc;
        logic                byp;
        logic [DW-1:0]       lv;
        logic [LANES*DW-1:0] x, ey;
        scl = $urandom_range(0, 7);
        sc  = (scl > MAX_SCALE) ? MAX_SCALE : scl;
        byp = 1'b0;
`ifdef GELU_BYPASS_EN
        byp = ($urandom_range(0, 3) == 0);
`endif
        for (int i = 0; i < LANES; i++) begin
            lv = DW'($urandom);
            x[i*DW +: DW]  = lv;
            ey[i*DW +: DW] = byp ? lv : DW'(gelu_ref(int'($signed(lv)), sc));
        end
        drive(scl, x, byp, ey, 1);
    endtask

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [LANES*DW-1:0] ey;
        int                  es, et;
        got_out = 1'b0;
        @(negedge clk);
        if (!rst) begin
            if (io.m_valid && io.m_ready) begin
                got_out = 1'b1;
                if (q_y.size() == 0) begin
                    check("spurious_out", q_y.size(), 1, 0);
                end else begin
                    ey = q_y.pop_front();
                    es = q_scl.pop_front();
                    et = q_tol.pop_front();
                    for (int i = 0; i < LANES; i++)
                        check("lane", int'($signed(io.m_y[i*DW +: DW])), int'($signed(ey[i*DW +: DW])), et);
                    check("m_scale", int'(io.m_scale), es, 0);
                    n_out++;
                end
            end
            if (io.s_valid && io.s_ready) begin
                q_y.push_back(cur_y);
                q_scl.push_back(cur_scl);
                q_tol.push_back(cur_tol);
                n_in++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        io.s_valid = 1'b0;
        io.m_ready = 1'b1;
        n = 0;
        while (q_y.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        check(tag, q_y.size(), 0, 0);
    endtask

    initial begin
        int                  lat, n0, o0, budget, hs;
        logic [LANES*DW-1:0] held_y;
        logic [SCALE_W-1:0]  held_s;

        rst        = 1'b1;
        io.s_valid = 1'b0;
        io.s_scale = '0;
        io.s_x     = '0;
        io.m_ready = 1'b0;
`ifdef GELU_BYPASS_EN
        io.s_bypass = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", int'(io.m_valid), 0, 0);
        check("rst_m_y", int'(io.m_y), 0, 0);
        check("rst_m_scale", int'(io.m_scale), 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_s_ready", int'(io.s_ready), 1, 0);

        // Single beat: latency and documented values
        io.m_ready = 1'b1;
        drive(2, pack4(8, -4, 0, 127), 1'b0, pack4(8, -1, 0, 127), 0);
        tick();
        io.s_valid = 1'b0;
        lat = 0;
        got_out = 1'b0;
        while (!got_out && lat < 30) begin
            tick();
            lat++;
        end
        check("latency", lat, LAT, 0);

        // Back-to-back directed beats, scale clamp, guaranteed-value boundaries
        drive(0, pack4(-128, 1, -1, 3), 1'b0, pack4(0, 1, 0, 3), 0);
        tick();
        drive(7, pack4(64, -64, 0, 100), 1'b0,
              pack4(gelu_ref(64, 6), gelu_ref(-64, 6), 0, gelu_ref(100, 6)), 0);
        cur_tol = 1;
        tick();
        drive(2, pack4(14, -16, 13, -15), 1'b0, pack4(14, 0, 13, 0), 0);
        tick();
        drain("directed_drain");

        // Random traffic with random backpressure
        n0 = n_in;
        o0 = n_out;
        budget = 0;
        while ((n_in - n0) < 200 && budget < 5000) begin
            if ($urandom_range(0, 9) < 6) rand_beat();
            else io.s_valid = 1'b0;
            io.m_ready = ($urandom_range(0, 9) < 6);
            tick();
            budget++;
        end
        check("rand_in", n_in - n0, 200, 0);
        drain("rand_drain");
        check("rand_count", n_out - o0, n_in - n0, 0);

        // Stall with a full pipeline
        io.m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rand_beat();
            tick();
        end
        io.m_ready = 1'b0;
        rand_beat();
        #1;
        held_y = io.m_y;
        held_s = io.m_scale;
        check("stall_m_valid", int'(io.m_valid), 1, 0);
        for (int c = 0; c < 5; c++) begin
            check("stall_s_ready", int'(io.s_ready), 0, 0);
            tick();
            for (int i = 0; i < LANES; i++)
                check("stall_hold_y", int'($signed(io.m_y[i*DW +: DW])), int'($signed(held_y[i*DW +: DW])), 0);
            check("stall_hold_scale", int'(io.m_scale), int'(held_s), 0);
        end
        io.m_ready = 1'b1;
        o0 = n_out;
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            rand_beat();
            tick();
            if (got_out) hs++;
        end
        check("resume_rate", hs, 10, 0);
        check("resume_count", n_out - o0, 10, 0);
        drain("stall_drain");

        // Reset with beats in flight
        io.m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rand_beat();
            tick();
        end
        rst = 1'b1;
        io.s_valid = 1'b0;
        tick();
        q_y.delete();
        q_scl.delete();
        q_tol.delete();
        rst = 1'b0;
        check("midrst_m_valid", int'(io.m_valid), 0, 0);
        o0 = n_out;
        drive(0, pack4(-128, 1, -1, 3), 1'b0, pack4(0, 1, 0, 3), 0);
        tick();
        drain("midrst_drain");
        check("midrst_outputs", n_out - o0, 1, 0);

`ifdef GELU_BYPASS_EN
        // Alternating bypass / GELU beats
        for (int c = 0; c < 6; c++) begin
            if (c % 2 == 0) drive(2, pack4(-4, -4, -4, -4), 1'b1, pack4(-4, -4, -4, -4), 0);
            else            drive(2, pack4(-4, -4, -4, -4), 1'b0, pack4(-1, -1, -1, -1), 0);
            tick();
        end
        drain("bypass_drain");
`endif

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule
